// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/UART handshake bundle for uart_tx_arbiter
//
// Purpose: groups the requester byte handshake and the UART write/busy
// signals. The slave modport is the arbiter view; the master modport is the
// view of the surrounding fabric (requesters plus the UART).
// Signals:
//   req_valid    [NREQ]    per-requester byte available
//   req_data     [8*NREQ]  byte of requester i on bits [8*i+7:8*i]
//   req_ready    [NREQ]    one-cycle one-hot consume pulse
//   req_lock     [NREQ]    packet lock (only when UART_ARB_LOCK_EN is defined)
//   uart_wr                write strobe to the UART
//   uart_tx_data [8]       byte to the UART
//   uart_busy              UART transmitter busy
//   grant_id     [3]       index of the last/current grantee
//   active                 high from ISSUE through WAIT_DONE
`timescale 1ns/1ps
interface uart_tx_arbiter_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
`ifdef UART_ARB_LOCK_EN
  logic [NREQ-1:0]   req_lock;
`endif
  logic              uart_wr;
  logic [7:0]        uart_tx_data;
  logic              uart_busy;
  logic [2:0]        grant_id;
  logic              active;

`ifdef UART_ARB_LOCK_EN
  modport slave (
    input  req_valid, req_data, req_lock, uart_busy,
    output req_ready, uart_wr, uart_tx_data, grant_id, active
  );
  modport master (
    output req_valid, req_data, req_lock, uart_busy,
    input  req_ready, uart_wr, uart_tx_data, grant_id, active
  );
`else
  modport slave (
    input  req_valid, req_data, uart_busy,
    output req_ready, uart_wr, uart_tx_data, grant_id, active
  );
  modport master (
    output req_valid, req_data, uart_busy,
    input  req_ready, uart_wr, uart_tx_data, grant_id, active
  );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin per-byte arbiter sharing one UART transmitter
//
// Purpose: grants one byte at a time from NREQ producers to a single UART,
// pacing itself from uart_busy. Optional packet lock via macro
// UART_ARB_LOCK_EN (adds req_lock to the interface).
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    uart_tx_arbiter_if.slave (requester handshake + UART strobe/busy)
// Parameters:
//   NREQ            number of requesters (1..8)
//   WAIT_START_MAX  cycles to wait for uart_busy to rise after a write
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int NREQ           = 2,
  parameter int WAIT_START_MAX = 3
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_arbiter_if.slave    bus
);

  localparam int CW = ($clog2(WAIT_START_MAX + 1) < 1) ? 1 : $clog2(WAIT_START_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [7:0]        data_q, data_d;
  logic [NREQ-1:0]   ready_q, ready_d;
  logic [2:0]        grant_q, grant_d;
  logic              active_q, active_d;
`ifdef UART_ARB_LOCK_EN
  // Lock only means something once 'last' names a requester that was
  // actually granted; out of reset last points at NREQ-1 by construction.
  logic              granted_q, granted_d;
  logic              lock_last;
`endif

  logic [NREQ-1:0]   elig;
  logic              win_found;
  logic [2:0]        win_idx;
  logic [7:0]        win_data;
  logic [NREQ-1:0]   win_onehot;

  // Winner = first eligible index scanning last+1, last+2, ... mod NREQ.
  // Offsets are walked from farthest to nearest so the nearest overwrites.
  always_comb begin
    elig = bus.req_valid;
`ifdef UART_ARB_LOCK_EN
    lock_last = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (3'(j) == last_q) lock_last = bus.req_lock[j];
    end
    if (granted_q && lock_last) begin
      for (int j = 0; j < NREQ; j++) begin
        if (3'(j) != last_q) elig[j] = 1'b0;
      end
    end
`endif
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (elig[j] && (j == ((int'(last_q) + k) % NREQ))) begin
          win_found = 1'b1;
          win_idx   = 3'(j);
        end
      end
    end
    win_data   = 8'h00;
    win_onehot = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (3'(j) == win_idx) begin
        win_data      = bus.req_data[8*j +: 8];
        win_onehot[j] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    data_d   = data_q;
    ready_d  = ready_q;
    grant_d  = grant_q;
    active_d = active_q;
`ifdef UART_ARB_LOCK_EN
    granted_d = granted_q;
`endif
    case (state_q)
      IDLE: begin
        if (!bus.uart_busy && win_found) begin
          data_d   = win_data;
          ready_d  = win_onehot;
          wr_d     = 1'b1;
          grant_d  = win_idx;
          last_d   = win_idx;
          active_d = 1'b1;
          state_d  = ISSUE;
`ifdef UART_ARB_LOCK_EN
          granted_d = 1'b1;
`endif
        end
      end
      ISSUE: begin
        wr_d    = 1'b0;
        ready_d = '0;
        cnt_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (bus.uart_busy) begin
          state_d = WAIT_DONE;
        end else begin
          // UART ignored the write: give up after WAIT_START_MAX cycles,
          // the byte is dropped silently.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(WAIT_START_MAX)) begin
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end
      end
      WAIT_DONE: begin
        if (!bus.uart_busy) begin
          state_d  = IDLE;
          active_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 3'(NREQ - 1);
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      data_q   <= 8'h00;
      ready_q  <= '0;
      grant_q  <= 3'd0;
      active_q <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      granted_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      grant_q  <= grant_d;
      active_q <= active_d;
`ifdef UART_ARB_LOCK_EN
      granted_q <= granted_d;
`endif
    end
  end

  assign bus.uart_wr      = wr_q;
  assign bus.uart_tx_data = data_q;
  assign bus.req_ready    = ready_q;
  assign bus.grant_id     = grant_q;
  assign bus.active       = active_q;

endmodule
